// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing from a 50 MHz clock: pixel counters, syncs, blank, DAC colour register and frame pulses.
// Colour/sync/blank lag DrawX/DrawY by one pixel (2 Clk); no backpressure, free-running once out of reset.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       frame_start,
  output logic       vblank_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       pix_tog;
  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       v_wrap;
  logic       visible;
  logic       hs_active;
  logic       vs_active;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_tog <= 1'b0;
    end else begin
      pix_tog <= ~pix_tog;
    end
  end

  assign pix_en = pix_tog;
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (pix_en) begin
      if (h_wrap) begin
        h_cnt <= 10'd0;
        v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_active = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs_active = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

  // Sampled with the pre-edge counters so colour, syncs and blank share one pixel of latency.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      VGA_R       <= 8'd0;
      VGA_G       <= 8'd0;
      VGA_B       <= 8'd0;
      VGA_BLANK_N <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
    end else if (pix_en) begin
      VGA_R       <= visible ? Red   : 8'd0;
      VGA_G       <= visible ? Green : 8'd0;
      VGA_B       <= visible ? Blue  : 8'd0;
      VGA_BLANK_N <= visible;
      VGA_HS      <= ~hs_active;
      VGA_VS      <= ~vs_active;
    end
  end

  // Updated every edge so each pulse self-clears on the following non-pixel edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      frame_start  <= pix_en && h_wrap && v_wrap;
      vblank_start <= pix_en && h_wrap && (v_cnt == V_VIS_LAST);
    end
  end

  assign DrawX      = h_cnt;
  assign DrawY      = v_cnt;
  assign VGA_CLK    = pix_tog;
  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (56x27) so full frames fit in a short run.
// A position-based model feeds a scoreboard; a vector table and event timings pin down hand-computed points.
module tb_vga_timing_gen;

  localparam int HV = 40, HF = 4, HS = 8, HB = 4, HT = HV + HF + HS + HB;
  localparam int VV = 20, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
  localparam int F  = HT * VT;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] Red, Green, Blue;
  logic [9:0] DrawX, DrawY;
  logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       frame_start, vblank_start;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Red(Red), .Green(Green), .Blue(Blue),
    .DrawX(DrawX), .DrawY(DrawY),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .frame_start(frame_start), .vblank_start(vblank_start)
  );

  always #5 Clk = ~Clk;

  // Combinational stand-in for the colour mapper.
  assign Red   = 8'hFF;
  assign Green = DrawX[7:0] ^ 8'h5A;
  assign Blue  = DrawY[7:0] + 8'h11;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vclk;
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic       sync_n;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       fs;
    logic       vb;
  } exp_t;

  typedef struct {
    int n;
    int x;
    int y;
    int r;
    int g;
    int blank_n;
    int hs;
    int vs;
  } vec_t;

  exp_t exp_q[$];
  int   n = 0;
  int   checks = 0;
  int   errors = 0;
  bit   rec = 1'b0;

  // Expected state after the n-th edge since reset release (n = 0: in reset).
  function automatic exp_t model(int e_n);
    exp_t e;
    int p, pos, q, qx, qy;
    logic vis;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (e_n == 0) return e;
    p = e_n / 2;
    pos = p % F;
    e.x = 10'(pos % HT);
    e.y = 10'(pos / HT);
    e.vclk = (e_n % 2) == 1;
    if (e_n >= 2) begin
      q  = (p - 1) % F;
      qx = q % HT;
      qy = q / HT;
      vis = (qx < HV) && (qy < VV);
      e.blank_n = vis;
      e.r  = vis ? 8'hFF : 8'h00;
      e.g  = vis ? (8'(qx) ^ 8'h5A) : 8'h00;
      e.b  = vis ? 8'(qy + 17) : 8'h00;
      e.hs = !((qx >= HV + HF) && (qx < HV + HF + HS));
      e.vs = !((qy >= VV + VF) && (qy < VV + VF + VS));
      e.fs = ((e_n % 2) == 0) && ((p % F) == 0);
      e.vb = ((e_n % 2) == 0) && ((p % F) == VV * HT);
    end
    return e;
  endfunction

  always @(posedge Clk) begin
    if (!Reset_n) n = 0;
    else n = n + 1;
    exp_q.push_back(model(n));
  end

  always @(negedge Clk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {DrawX, DrawY, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
           VGA_R, VGA_G, VGA_B, frame_start, vblank_start};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard n=%0d got x=%0d y=%0d vec=%h required x=%0d y=%0d vec=%h",
                 n, a.x, a.y, a, e.x, e.y, e);
      end
    end
  end

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  // Event timestamps (edge numbers since release) for the timing checks.
  int hs_fall[$], hs_rise[$], fs_n[$], fs_xy[$];
  int x44_n = -1, y22_n = -1, vb_n = -1, vb_x = -1, vb_y = -1, vs_fall = -1, vs_rise = -1;
  logic prev_hs = 1'b1, prev_vs = 1'b1;

  always @(negedge Clk) begin
    if (rec) begin
      if (prev_hs && !VGA_HS) hs_fall.push_back(n);
      if (!prev_hs && VGA_HS) hs_rise.push_back(n);
      if (x44_n < 0 && DrawX == 10'd44 && DrawY == 10'd0) x44_n = n;
      if (y22_n < 0 && DrawY == 10'd22 && DrawX == 10'd0) y22_n = n;
      if (frame_start) begin
        fs_n.push_back(n);
        fs_xy.push_back(int'({DrawX, DrawY}));
      end
      if (vblank_start && vb_n < 0) begin
        vb_n = n;
        vb_x = int'(DrawX);
        vb_y = int'(DrawY);
      end
      if (prev_vs && !VGA_VS && vs_fall < 0) vs_fall = n;
      if (!prev_vs && VGA_VS && vs_rise < 0) vs_rise = n;
      prev_hs = VGA_HS;
      prev_vs = VGA_VS;
    end
  end

  vec_t tbl[16];

  initial begin
    int guard;
    tbl[0]  = '{1,    0,  0, 8'h00, 8'h00, 0, 1, 1};
    tbl[1]  = '{2,    1,  0, 8'hFF, 8'h5A, 1, 1, 1};
    tbl[2]  = '{4,    2,  0, 8'hFF, 8'h5B, 1, 1, 1};
    tbl[3]  = '{80,  40,  0, 8'hFF, 8'h7D, 1, 1, 1};
    tbl[4]  = '{82,  41,  0, 8'h00, 8'h00, 0, 1, 1};
    tbl[5]  = '{90,  45,  0, 8'h00, 8'h00, 0, 0, 1};
    tbl[6]  = '{104, 52,  0, 8'h00, 8'h00, 0, 0, 1};
    tbl[7]  = '{106, 53,  0, 8'h00, 8'h00, 0, 1, 1};
    tbl[8]  = '{112,  0,  1, 8'h00, 8'h00, 0, 1, 1};
    tbl[9]  = '{114,  1,  1, 8'hFF, 8'h5A, 1, 1, 1};
    tbl[10] = '{2242, 1, 20, 8'h00, 8'h00, 0, 1, 1};
    tbl[11] = '{2466, 1, 22, 8'h00, 8'h00, 0, 1, 0};
    tbl[12] = '{2688, 0, 24, 8'h00, 8'h00, 0, 1, 0};
    tbl[13] = '{2690, 1, 24, 8'h00, 8'h00, 0, 1, 1};
    tbl[14] = '{3024, 0,  0, 8'h00, 8'h00, 0, 1, 1};
    tbl[15] = '{3026, 1,  0, 8'hFF, 8'h5A, 1, 1, 1};

    repeat (5) @(posedge Clk);
    @(negedge Clk);
    chk("rst_drawx", int'(DrawX), 0);
    chk("rst_drawy", int'(DrawY), 0);
    chk("rst_hs", int'(VGA_HS), 1);
    chk("rst_vs", int'(VGA_VS), 1);
    chk("rst_blank_n", int'(VGA_BLANK_N), 0);
    chk("rst_red", int'(VGA_R), 0);
    chk("rst_sync_n", int'(VGA_SYNC_N), 0);
    Reset_n = 1'b1;
    rec = 1'b1;

    for (int i = 0; i < 16; i++) begin
      guard = 0;
      while (n < tbl[i].n && guard < 10000) begin
        @(negedge Clk);
        guard++;
      end
      chk($sformatf("vec%0d_edge", i), n, tbl[i].n);
      chk($sformatf("vec%0d_drawx", i), int'(DrawX), tbl[i].x);
      chk($sformatf("vec%0d_drawy", i), int'(DrawY), tbl[i].y);
      chk($sformatf("vec%0d_red", i), int'(VGA_R), tbl[i].r);
      chk($sformatf("vec%0d_green", i), int'(VGA_G), tbl[i].g);
      chk($sformatf("vec%0d_blank_n", i), int'(VGA_BLANK_N), tbl[i].blank_n);
      chk($sformatf("vec%0d_hs", i), int'(VGA_HS), tbl[i].hs);
      chk($sformatf("vec%0d_vs", i), int'(VGA_VS), tbl[i].vs);
    end

    while (n < 6100) @(negedge Clk);
    rec = 1'b0;

    chk("x44_edge", x44_n, 88);
    chk("hs_fall_edge", (hs_fall.size() > 0) ? hs_fall[0] : -1, 90);
    chk("hs_fall_after_x44", (hs_fall.size() > 0) ? hs_fall[0] - x44_n : -1, 2);
    chk("hs_low_clk", (hs_rise.size() > 0 && hs_fall.size() > 0) ? hs_rise[0] - hs_fall[0] : -1, 2 * HS);
    chk("line_clk", (hs_fall.size() > 1) ? hs_fall[1] - hs_fall[0] : -1, 2 * HT);
    chk("fs_count", fs_n.size(), 2);
    chk("fs_first_edge", (fs_n.size() > 0) ? fs_n[0] : -1, 2 * F);
    chk("fs_period", (fs_n.size() > 1) ? fs_n[1] - fs_n[0] : -1, 2 * F);
    chk("fs_xy", (fs_xy.size() > 0) ? fs_xy[0] : -1, 0);
    chk("vb_edge", vb_n, 2 * VV * HT);
    chk("vb_drawx", vb_x, 0);
    chk("vb_drawy", vb_y, VV);
    chk("fs_minus_vb", (fs_n.size() > 0) ? fs_n[0] - vb_n : -1, 2 * (VT - VV) * HT);
    chk("y22_edge", y22_n, 2464);
    chk("vs_fall_after_y22", vs_fall - y22_n, 2);
    chk("vs_low_clk", vs_rise - vs_fall, 2 * VS * HT);

    // Asynchronous reset in mid-frame, asserted between clock edges.
    guard = 0;
    while (!(DrawX == 10'd30 && DrawY == 10'd10) && guard < 4000) begin
      @(negedge Clk);
      guard++;
    end
    chk("midreset_reach_point", int'({DrawX, DrawY}), int'({10'd30, 10'd10}));
    #2;
    Reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midreset_drawx", int'(DrawX), 0);
    chk("midreset_drawy", int'(DrawY), 0);
    chk("midreset_vga_clk", int'(VGA_CLK), 0);
    chk("midreset_hs", int'(VGA_HS), 1);
    chk("midreset_vs", int'(VGA_VS), 1);
    chk("midreset_blank_n", int'(VGA_BLANK_N), 0);
    chk("midreset_rgb", int'({VGA_R, VGA_G, VGA_B}), 0);
    chk("midreset_pulses", int'({frame_start, vblank_start}), 0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    guard = 0;
    do begin
      @(negedge Clk);
      guard++;
    end while (!frame_start && guard < 4000);
    chk("midreset_fs_edge", n, 2 * F);
    chk("midreset_fs_xy", int'({DrawX, DrawY}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
